// File: rtl/lcd_pkg.sv
// Shared constants and state encoding for the LCD frame writer and its bus transaction engine.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;

    // Default bus timing at 50 MHz
    localparam int unsigned DEF_SETUP_CYC  = 2;
    localparam int unsigned DEF_E_HIGH_CYC = 15;
    localparam int unsigned DEF_HOLD_CYC   = 2;
    localparam int unsigned DEF_EXEC_CYC   = 2000;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SETUP,
        PULSE,
        HOLD,
        EXEC,
        NEXT
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_bus_xfer.sv
// One HD44780 write transaction: SETUP -> PULSE (E high) -> HOLD -> EXEC wait, then done.
module lcd_bus_xfer
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
    parameter int unsigned E_HIGH_CYC = DEF_E_HIGH_CYC,
    parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
    parameter int unsigned EXEC_CYC   = DEF_EXEC_CYC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    output logic       RS,
    output logic       E,
    output logic [7:0] DATA,
    output logic       done
);

    localparam int unsigned MAX_CYC = max_u(max_u(SETUP_CYC, E_HIGH_CYC), max_u(HOLD_CYC, EXEC_CYC));
    localparam int unsigned TW      = $clog2(MAX_CYC + 1);

    state_t        st;
    logic [TW-1:0] timer;
    logic          timer_last;

    assign timer_last = (timer == TW'(1));
    // Combinational so the caller can launch the next transaction without a dead cycle
    assign done       = (st == EXEC) && timer_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            st    <= IDLE;
            timer <= '0;
            RS    <= 1'b0;
            E     <= 1'b0;
            DATA  <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (start) begin
                        st    <= SETUP;
                        timer <= TW'(SETUP_CYC);
                        RS    <= rs;
                        DATA  <= data;
                    end
                end
                SETUP: begin
                    if (timer_last) begin
                        st    <= PULSE;
                        timer <= TW'(E_HIGH_CYC);
                        E     <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                PULSE: begin
                    if (timer_last) begin
                        st    <= HOLD;
                        timer <= TW'(HOLD_CYC);
                        E     <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                HOLD: begin
                    if (timer_last) begin
                        st    <= EXEC;
                        timer <= TW'(EXEC_CYC);
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                EXEC: begin
                    if (timer_last) begin
                        st    <= IDLE;
                        timer <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    st    <= IDLE;
                    timer <= '0;
                    E     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_frame_writer.sv
// Continuously writes a LINES x CHARS character frame to an HD44780 LCD once initialised.
// Optional LCD_DIRTY_SKIP_EN: skip frames identical to the previous snapshot.
module lcd_frame_writer
    import lcd_pkg::*;
#(
    parameter int unsigned              LINES       = 4,
    parameter int unsigned              CHARS       = 20,
    parameter logic [0:LINES-1][6:0]    LINE_STARTS = {7'h00, 7'h40, 7'h14, 7'h54},
    parameter int unsigned              SETUP_CYC   = DEF_SETUP_CYC,
    parameter int unsigned              E_HIGH_CYC  = DEF_E_HIGH_CYC,
    parameter int unsigned              HOLD_CYC    = DEF_HOLD_CYC,
    parameter int unsigned              EXEC_CYC    = DEF_EXEC_CYC
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       initilized,
    input  logic [LINES*CHARS*8-1:0]   display_chars,
    output logic                       RS,
    output logic                       RW,
    output logic                       E,
    output logic [7:0]                 DATA,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int unsigned LW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int unsigned CW = (CHARS > 1) ? $clog2(CHARS) : 1;

    // SETUP here stands for the whole SETUP..EXEC run, which lcd_bus_xfer times
    state_t                    st;
    logic [LW-1:0]             line;
    logic [CW-1:0]             col;
    logic                      addr_phase;
    logic [LINES*CHARS*8-1:0]  snapshot;

    logic [LW-1:0]             n_line;
    logic [CW-1:0]             n_col;
    logic                      n_addr;
    logic                      last_char;
    logic [7:0]                tx_char;
    logic                      tx_rs;
    logic [7:0]                tx_data;
    logic                      skip;
    logic                      start;
    logic                      xfer_done;

`ifdef LCD_DIRTY_SKIP_EN
    logic snap_valid;
`endif

    assign RW = 1'b0;

    // Pointer of the transaction that starts this cycle (from LATCH or NEXT)
    always_comb begin
        n_line    = line;
        n_col     = col;
        n_addr    = addr_phase;
        last_char = 1'b0;
        if (st == LATCH) begin
            n_line = '0;
            n_col  = '0;
            n_addr = 1'b1;
        end else if (addr_phase) begin
            n_addr = 1'b0;
            n_col  = '0;
        end else if (col != CW'(CHARS - 1)) begin
            n_col = col + 1'b1;
        end else if (line != LW'(LINES - 1)) begin
            n_line = line + 1'b1;
            n_col  = '0;
            n_addr = 1'b1;
        end else begin
            last_char = 1'b1;
        end
    end

    always_comb begin
        tx_char = '0;
        for (int unsigned l = 0; l < LINES; l++) begin
            for (int unsigned c = 0; c < CHARS; c++) begin
                if (n_line == LW'(l) && n_col == CW'(c)) begin
                    tx_char = snapshot[(l*CHARS + c)*8 +: 8];
                end
            end
        end
    end

    assign tx_rs   = ~n_addr;
    assign tx_data = n_addr ? (LCD_CMD_SET_DDRAM | {1'b0, LINE_STARTS[n_line]}) : tx_char;

`ifdef LCD_DIRTY_SKIP_EN
    assign skip = snap_valid && (display_chars == snapshot);
`else
    assign skip = 1'b0;
`endif

    assign start = ((st == LATCH) && !skip) || ((st == NEXT) && initilized && !last_char);

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= IDLE;
            line       <= '0;
            col        <= '0;
            addr_phase <= 1'b0;
            snapshot   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef LCD_DIRTY_SKIP_EN
            snap_valid <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (st)
                IDLE: begin
                    if (initilized) begin
                        st   <= LATCH;
                        busy <= 1'b1;
                    end
                end
                LATCH: begin
                    snapshot   <= display_chars;
                    line       <= n_line;
                    col        <= n_col;
                    addr_phase <= n_addr;
`ifdef LCD_DIRTY_SKIP_EN
                    snap_valid <= 1'b1;
`endif
                    if (skip) begin
                        st   <= IDLE;
                        busy <= 1'b0;
                    end else begin
                        st <= SETUP;
                    end
                end
                SETUP: begin
                    if (xfer_done) begin
                        st <= NEXT;
                    end
                end
                NEXT: begin
                    if (!initilized || last_char) begin
                        st         <= IDLE;
                        busy       <= 1'b0;
                        frame_done <= initilized;
                        line       <= '0;
                        col        <= '0;
                        addr_phase <= 1'b0;
                    end else begin
                        st         <= SETUP;
                        line       <= n_line;
                        col        <= n_col;
                        addr_phase <= n_addr;
                    end
                end
                default: begin
                    st   <= IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end

    lcd_bus_xfer #(
        .SETUP_CYC  (SETUP_CYC),
        .E_HIGH_CYC (E_HIGH_CYC),
        .HOLD_CYC   (HOLD_CYC),
        .EXEC_CYC   (EXEC_CYC)
    ) u_xfer (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .rs    (tx_rs),
        .data  (tx_data),
        .RS    (RS),
        .E     (E),
        .DATA  (DATA),
        .done  (xfer_done)
    );

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Self-checking bench for lcd_frame_writer with a 2x3 display and short bus timing.
module tb_lcd_frame_writer;

    localparam int unsigned LINES  = 2;
    localparam int unsigned CHARS  = 3;
    localparam int unsigned E_HIGH = 2;

    typedef struct packed {
        logic [47:0]      frame;
        logic [0:7][8:0]  exp;    // {RS, DATA} per E pulse, in bus order
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        initilized = 1'b0;
    logic [47:0] display_chars = '0;
    logic        RS, RW, E, busy, frame_done;
    logic [7:0]  DATA;

    int          checks = 0;
    int          errors = 0;
    int          e_rises = 0;
    int          fd_count = 0;
    int          e_width = 0;
    bit          skip_width = 1'b0;
    logic        e_q = 1'b0;
    logic        fd_q = 1'b0;
    logic [8:0]  prev_bus = '0;
    logic [8:0]  cap_bus = '0;
    logic [8:0]  sb[$];

    always #5 clk = ~clk;

    lcd_frame_writer #(
        .LINES       (LINES),
        .CHARS       (CHARS),
        .LINE_STARTS ({7'h00, 7'h40}),
        .SETUP_CYC   (1),
        .E_HIGH_CYC  (E_HIGH),
        .HOLD_CYC    (1),
        .EXEC_CYC    (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .initilized    (initilized),
        .display_chars (display_chars),
        .RS            (RS),
        .RW            (RW),
        .E             (E),
        .DATA          (DATA),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bus monitor: pops the scoreboard on every E rise and checks pulse shape
    always @(negedge clk) begin
        if (E && !e_q) begin
            e_rises++;
            e_width = 1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_E: got %0h, expected no pulse", {RS, DATA});
            end else begin
                check("pulse_bus", {23'd0, RS, DATA}, {23'd0, sb.pop_front()});
            end
            check("setup_stable", {23'd0, prev_bus}, {23'd0, RS, DATA});
            cap_bus = {RS, DATA};
        end else if (E) begin
            e_width++;
            check("e_high_stable", {23'd0, RS, DATA}, {23'd0, cap_bus});
        end else if (e_q && !skip_width) begin
            check("e_width", e_width, E_HIGH);
            check("hold_stable", {23'd0, RS, DATA}, {23'd0, cap_bus});
        end
        if (frame_done) begin
            fd_count++;
            check("frame_done_width", {31'd0, fd_q}, 32'd0);
        end
        e_q      = E;
        fd_q     = frame_done;
        prev_bus = {RS, DATA};
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_frame(input vec_t v);
        for (int k = 0; k < 8; k++) sb.push_back(v.exp[k]);
    endtask

    task automatic wait_fd(input string name, input int target);
        for (int n = 0; n < 400 && fd_count < target; n++) tick();
        check(name, fd_count, target);
    endtask

    task automatic wait_rises(input string name, input int target);
        for (int n = 0; n < 400 && e_rises < target; n++) tick();
        check(name, e_rises, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[3];
        vec_t v_qqq, v_012;
        int   base, nz;

        tbl[0].frame = {8'h7A, 8'h79, 8'h78, 8'h43, 8'h42, 8'h41};
        tbl[0].exp   = {9'h080, 9'h141, 9'h142, 9'h143, 9'h0C0, 9'h178, 9'h179, 9'h17A};
        tbl[1].frame = {8'h35, 8'h34, 8'h33, 8'h32, 8'h31, 8'h30};
        tbl[1].exp   = {9'h080, 9'h130, 9'h131, 9'h132, 9'h0C0, 9'h133, 9'h134, 9'h135};
        tbl[2].frame = {8'hFE, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h00};
        tbl[2].exp   = {9'h080, 9'h100, 9'h1FF, 9'h180, 9'h0C0, 9'h17F, 9'h101, 9'h1FE};
        v_qqq.frame  = {6{8'h51}};
        v_qqq.exp    = {9'h080, 9'h151, 9'h151, 9'h151, 9'h0C0, 9'h151, 9'h151, 9'h151};
        v_012        = tbl[1];

        // Reset state
        repeat (3) tick();
        check("rst_RS", {31'd0, RS}, 0);
        check("rst_RW", {31'd0, RW}, 0);
        check("rst_E", {31'd0, E}, 0);
        check("rst_DATA", {24'd0, DATA}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_frame_done", {31'd0, frame_done}, 0);
        reset = 1'b0;

        // Gating: bus stays quiet while not initialised
        nz = 0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (E || busy || DATA != 8'h00) nz++;
        end
        check("gating_quiet", nz, 0);
        display_chars = tbl[0].frame;
        push_frame(tbl[0]);
        initilized = 1'b1;
        tick();
        check("latch_busy", {31'd0, busy}, 1);
        check("latch_E", {31'd0, E}, 0);

        // Table-driven frames, each loaded right after the previous frame_done
        for (int i = 0; i < 3; i++) begin
            wait_fd("frame_done_count", i + 1);
            check("frame_sb_empty", sb.size(), 0);
            if (i < 2) begin
                display_chars = tbl[i+1].frame;
                push_frame(tbl[i+1]);
            end
        end

        // Snapshot: change the frame while the second character is on the bus
        display_chars = tbl[0].frame;
        push_frame(tbl[0]);
        base = e_rises;
        wait_rises("snap_reach_2nd_char", base + 3);
        display_chars = v_qqq.frame;
        push_frame(v_qqq);
        wait_fd("snap_old_frame_done", 4);
        check("snap_pending", sb.size(), 8);
        wait_fd("snap_new_frame_done", 5);
        check("snap_sb_empty", sb.size(), 0);

        // Deassert initilized during the third pulse of a frame
        display_chars = v_012.frame;
        for (int k = 0; k < 3; k++) sb.push_back(v_012.exp[k]);
        base = e_rises;
        wait_rises("deassert_reach", base + 3);
        initilized = 1'b0;
        repeat (100) tick();
        check("deassert_no_more_E", e_rises, base + 3);
        check("deassert_no_frame_done", fd_count, 5);
        check("deassert_busy", {31'd0, busy}, 0);
        check("deassert_sb_empty", sb.size(), 0);

        // Reset while E is high
        skip_width = 1'b1;
        sb.push_back(9'h080);
        initilized = 1'b1;
        base = e_rises;
        wait_rises("reset_reach_E", base + 1);
        reset = 1'b1;
        tick();
        check("reset_mid_E", {31'd0, E}, 0);
        check("reset_mid_busy", {31'd0, busy}, 0);
        check("reset_mid_DATA", {24'd0, DATA}, 0);
        tick();
        skip_width = 1'b0;
        push_frame(v_012);
        reset = 1'b0;
        wait_fd("reset_restart_frame", 6);
        check("reset_sb_empty", sb.size(), 0);
        initilized = 1'b0;
        repeat (20) tick();

`ifdef LCD_DIRTY_SKIP_EN
        // Unchanged frame is skipped; a single changed byte writes one frame
        initilized = 1'b1;
        base = e_rises;
        repeat (200) tick();
        check("skip_no_E", e_rises, base);
        check("skip_no_frame_done", fd_count, 6);
        display_chars = {8'h39, v_012.frame[39:0]};
        push_frame('{frame: display_chars,
                     exp: {9'h080, 9'h130, 9'h131, 9'h132, 9'h0C0, 9'h133, 9'h134, 9'h139}});
        wait_fd("skip_dirty_frame", 7);
        repeat (100) tick();
        check("skip_one_frame_only", e_rises, base + 8);
        initilized = 1'b0;
        repeat (20) tick();
`endif

        check("final_sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
